// File: rtl/writeback_regfile_pkg.sv
// Shared sizing, the register-index type and the PC register alias used by
// the write-back register file and its storage sub-module.
// Optional feature macro used by the top: WB_BYPASS_EN.
package writeback_regfile_pkg;

    localparam int DW    = 32;
    localparam int NREGS = 16;
    localparam int AW    = $clog2(NREGS);
    localparam int CNTW  = 16;

    typedef logic [AW-1:0] reg_idx_t;

    // r15 is the PC alias: never stored, reads return PC+8.
    localparam reg_idx_t REG_PC = 4'd15;

endpackage : writeback_regfile_pkg

// File: rtl/regfile_2r1w.sv
// Storage for r0..r14: two asynchronous read ports, one synchronous write port.
// Ports: clk, rst_n (async active-low clear), i_we/i_wa/i_wd write port,
//        i_ra1/i_ra2 read addresses, o_rd1/o_rd2 read data (0 for index 15).
module regfile_2r1w
    import writeback_regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  reg_idx_t      i_wa,
    input  logic [DW-1:0] i_wd,
    input  reg_idx_t      i_ra1,
    input  reg_idx_t      i_ra2,
    output logic [DW-1:0] o_rd1,
    output logic [DW-1:0] o_rd2
);

    // Only NREGS-1 entries exist; the PC alias has no storage.
    logic [DW-1:0] r_mem [NREGS-1];

    for (genvar g = 0; g < NREGS - 1; g++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mem[g] <= '0;
            end else if (i_we && (i_wa == reg_idx_t'(g))) begin
                r_mem[g] <= i_wd;
            end
        end
    end

    // Explicit compare-mux keeps index 15 from addressing a missing entry.
    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        for (int i = 0; i < NREGS - 1; i++) begin
            if (i_ra1 == reg_idx_t'(i)) o_rd1 = r_mem[i];
            if (i_ra2 == reg_idx_t'(i)) o_rd2 = r_mem[i];
        end
    end

endmodule : regfile_2r1w

// File: rtl/writeback_regfile.sv
// Write-back commit stage: result mux, 15-entry register file with r15 = PC+8,
// zero-flag register and saturating retired-write counter; commits on rising clk.
// Ports: clk, reset (async active-low), W-stage controls/data in, decode read
//        ports RA1D/RA2D -> RD1D/RD2D, ResultW, FlagZero, RetireCount out.
// Optional: define WB_BYPASS_EN to forward ResultW to a read port that hits
// the register being written this cycle.
module writeback_regfile
    import writeback_regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic            MemtoRegW,
    input  logic            FlagsWriteW,
    input  logic            ALUFlagZeroW,
    input  reg_idx_t        WA3W,
    input  logic [DW-1:0]   ReadDataW,
    input  logic [DW-1:0]   ALUOutW,
    input  logic [DW-1:0]   PCPlus8D,
    input  reg_idx_t        RA1D,
    input  reg_idx_t        RA2D,
    output logic [DW-1:0]   RD1D,
    output logic [DW-1:0]   RD2D,
    output logic [DW-1:0]   ResultW,
    output logic            FlagZero,
    output logic [CNTW-1:0] RetireCount
);

    logic            w_rf_we;
    logic [DW-1:0]   w_rf_rd1;
    logic [DW-1:0]   w_rf_rd2;
    logic            w_retire;
    logic            r_flag_zero;
    logic [CNTW-1:0] r_retire_cnt;

    assign ResultW  = MemtoRegW ? ReadDataW : ALUOutW;
    // Writes aimed at the PC alias are dropped and do not count as retired.
    assign w_rf_we  = RegWriteW && (WA3W != REG_PC);
    assign w_retire = w_rf_we || FlagsWriteW;

    regfile_2r1w u_rf (
        .clk   (clk),
        .rst_n (reset),
        .i_we  (w_rf_we),
        .i_wa  (WA3W),
        .i_wd  (ResultW),
        .i_ra1 (RA1D),
        .i_ra2 (RA2D),
        .o_rd1 (w_rf_rd1),
        .o_rd2 (w_rf_rd2)
    );

`ifdef WB_BYPASS_EN
    // Bypass is suppressed in reset so stored registers read as zero there.
    logic w_byp1;
    logic w_byp2;
    assign w_byp1 = reset && w_rf_we && (WA3W == RA1D);
    assign w_byp2 = reset && w_rf_we && (WA3W == RA2D);

    always_comb begin
        RD1D = w_byp1 ? ResultW : w_rf_rd1;
        RD2D = w_byp2 ? ResultW : w_rf_rd2;
        if (RA1D == REG_PC) RD1D = PCPlus8D;
        if (RA2D == REG_PC) RD2D = PCPlus8D;
    end
`else
    always_comb begin
        RD1D = w_rf_rd1;
        RD2D = w_rf_rd2;
        if (RA1D == REG_PC) RD1D = PCPlus8D;
        if (RA2D == REG_PC) RD2D = PCPlus8D;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag_zero <= 1'b0;
        end else if (FlagsWriteW) begin
            r_flag_zero <= ALUFlagZeroW;
        end
    end

    // One increment per cycle even when both a register and the flag commit;
    // sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_cnt <= '0;
        end else if (w_retire && (r_retire_cnt != {CNTW{1'b1}})) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign FlagZero    = r_flag_zero;
    assign RetireCount = r_retire_cnt;

endmodule : writeback_regfile

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile; expected values are hand-computed
// constants. Inputs change 1 time unit after a rising edge.
module tb_writeback_regfile;
    import writeback_regfile_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            RegWriteW, MemtoRegW, FlagsWriteW, ALUFlagZeroW;
    reg_idx_t        WA3W, RA1D, RA2D;
    logic [DW-1:0]   ReadDataW, ALUOutW, PCPlus8D;
    logic [DW-1:0]   RD1D, RD2D, ResultW;
    logic            FlagZero;
    logic [CNTW-1:0] RetireCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk          (clk),
        .reset        (reset),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .FlagsWriteW  (FlagsWriteW),
        .ALUFlagZeroW (ALUFlagZeroW),
        .WA3W         (WA3W),
        .ReadDataW    (ReadDataW),
        .ALUOutW      (ALUOutW),
        .PCPlus8D     (PCPlus8D),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RD1D         (RD1D),
        .RD2D         (RD2D),
        .ResultW      (ResultW),
        .FlagZero     (FlagZero),
        .RetireCount  (RetireCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; sample 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWriteW    = 1'b0;
        FlagsWriteW  = 1'b0;
        ALUFlagZeroW = 1'b0;
        MemtoRegW    = 1'b0;
    endtask

    logic [31:0] exp_same;

    initial begin
        reset = 1'b0;
        idle();
        WA3W = '0; RA1D = '0; RA2D = 4'd15;
        ReadDataW = '0; ALUOutW = '0; PCPlus8D = 32'h100;
        #2;
        chk("rst_rd1_r0",   RD1D, 32'h0);
        chk("rst_rd2_r15",  RD2D, 32'h100);
        chk("rst_flag",     {31'b0, FlagZero}, 32'h0);
        chk("rst_cnt",      {16'b0, RetireCount}, 32'h0);
        step();
        #2 reset = 1'b1;
        step();

        // Load result selected from ReadDataW into r5.
        RegWriteW = 1'b1; MemtoRegW = 1'b1; WA3W = 4'd5;
        ReadDataW = 32'hDEADBEEF; ALUOutW = 32'h1; RA1D = 4'd5;
        #1 chk("resultw_mem", ResultW, 32'hDEADBEEF);
        step();
        idle();
        #1;
        chk("r5_read",   RD1D, 32'hDEADBEEF);
        chk("cnt_after_r5", {16'b0, RetireCount}, 32'h1);

        // Write to r15 is dropped; read returns PC+8 even before the edge.
        RegWriteW = 1'b1; MemtoRegW = 1'b0; WA3W = 4'd15; ALUOutW = 32'hAAAA;
        RA2D = 4'd15;
        #1;
        chk("resultw_alu", ResultW, 32'hAAAA);
        chk("r15_pre",     RD2D, 32'h100);
        step();
        idle();
        #1;
        chk("r15_post",     RD2D, 32'h100);
        chk("cnt_r15_drop", {16'b0, RetireCount}, 32'h1);

        // Flag and register commit together: counter +1 only.
        RegWriteW = 1'b1; WA3W = 4'd2; ALUOutW = 32'h22;
        FlagsWriteW = 1'b1; ALUFlagZeroW = 1'b1; RA1D = 4'd2;
        step();
        idle();
        #1;
        chk("flag_set",  {31'b0, FlagZero}, 32'h1);
        chk("r2_read",   RD1D, 32'h22);
        chk("cnt_both",  {16'b0, RetireCount}, 32'h2);

        // Flag-only write clears; then flag holds when not enabled.
        FlagsWriteW = 1'b1; ALUFlagZeroW = 1'b0;
        step();
        FlagsWriteW = 1'b0; ALUFlagZeroW = 1'b1;
        #1;
        chk("flag_clr",  {31'b0, FlagZero}, 32'h0);
        chk("cnt_flag",  {16'b0, RetireCount}, 32'h3);
        step();
        idle();
        #1;
        chk("flag_hold", {31'b0, FlagZero}, 32'h0);
        chk("cnt_hold",  {16'b0, RetireCount}, 32'h3);

        // Same-cycle write/read of r7 (old value 0x11).
        RegWriteW = 1'b1; WA3W = 4'd7; ALUOutW = 32'h11;
        step();
        ALUOutW = 32'h55; RA1D = 4'd7; RA2D = 4'd7;
`ifdef WB_BYPASS_EN
        exp_same = 32'h55;
`else
        exp_same = 32'h11;
`endif
        #1;
        chk("r7_pre_rd1", RD1D, exp_same);
        chk("r7_pre_rd2", RD2D, exp_same);
        step();
        idle();
        #1;
        chk("r7_post_rd1", RD1D, 32'h55);
        chk("r7_post_rd2", RD2D, 32'h55);
        chk("cnt_r7",      {16'b0, RetireCount}, 32'h5);

        // Mid-cycle async reset with a write pending.
        RegWriteW = 1'b1; WA3W = 4'd3; ALUOutW = 32'h1234; RA1D = 4'd3; RA2D = 4'd15;
        FlagsWriteW = 1'b1; ALUFlagZeroW = 1'b1;
        step();
        ALUOutW = 32'h9999;
        #1;
        chk("r3_before_rst",   RD1D, (exp_same == 32'h55) ? 32'h9999 : 32'h1234);
        chk("flag_before_rst", {31'b0, FlagZero}, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("r3_in_rst",   RD1D, 32'h0);
        chk("pc_in_rst",   RD2D, 32'h100);
        chk("flag_in_rst", {31'b0, FlagZero}, 32'h0);
        chk("cnt_in_rst",  {16'b0, RetireCount}, 32'h0);
        chk("resw_in_rst", ResultW, 32'h9999);
        step();
        chk("r3_rst_edge",  RD1D, 32'h0);
        chk("cnt_rst_edge", {16'b0, RetireCount}, 32'h0);
        idle();
        #2 reset = 1'b1;
        RegWriteW = 1'b1; WA3W = 4'd4; ALUOutW = 32'h44; RA1D = 4'd4;
        step();
        idle();
        #1;
        chk("r4_after_rst",  RD1D, 32'h44);
        chk("cnt_after_rst", {16'b0, RetireCount}, 32'h1);
        RA2D = 4'd3;
        #1 chk("r3_lost", RD2D, 32'h0);

        // Drive the counter to 0xFFFE with flag writes, then saturate.
        FlagsWriteW = 1'b1;
        repeat (32'hFFFD) @(posedge clk);
        #1;
        FlagsWriteW = 1'b0;
        chk("cnt_fffe", {16'b0, RetireCount}, 32'hFFFE);
        RegWriteW = 1'b1; WA3W = 4'd1; ALUOutW = 32'h1;
        step();
        chk("sat_1", {16'b0, RetireCount}, 32'hFFFF);
        step();
        chk("sat_2", {16'b0, RetireCount}, 32'hFFFF);
        step();
        chk("sat_3", {16'b0, RetireCount}, 32'hFFFF);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_writeback_regfile

// File: doc/writeback_regfile.md
# writeback_regfile

Write-back end of the MEM/WB interface: consumes the W-stage signals latched by the MEM/WB segment register and commits them to architectural state. Holds the 16×32 register file, the zero-flag register and a retired-write counter. Serves two combinational read ports to the decode stage. Sits between the MEM/WB segment register (upstream) and the decode-stage operand fetch (downstream).

## Interface
- `NREGS`, 16: architectural registers; index width is `$clog2(NREGS)` = 4
- `DW`, 32: data width
- `CNTW`, 16: retired-write counter width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state while low
- `RegWriteW`  in  1  register write enable from the W stage
- `MemtoRegW`  in  1  result select: 1 = `ReadDataW`, 0 = `ALUOutW`
- `FlagsWriteW`  in  1  zero-flag update enable
- `ALUFlagZeroW`  in  1  zero flag value to commit
- `WA3W`  in  4  destination register index
- `ReadDataW`  in  32  load data
- `ALUOutW`  in  32  ALU result
- `PCPlus8D`  in  32  value returned for reads of r15
- `RA1D`, `RA2D`  in  4  decode read addresses
- `RD1D`, `RD2D`  out  32  decode read data
- `ResultW`  out  32  selected write-back value
- `FlagZero`  out  1  committed zero flag
- `RetireCount`  out  16  count of committed register/flag writes

## Operation
- `ResultW` = `MemtoRegW ? ReadDataW : ALUOutW`, combinational.
- Register write: on rising `clk`, if `RegWriteW` and `WA3W != 15`, `rf[WA3W] <= ResultW`. Writes to r15 are dropped; r15 is not stored.
- Reads: `RDnD = (RAnD == 15) ? PCPlus8D : rf[RAnD]`, combinational, both ports independent; same address on both ports returns identical data.
- Flag: on rising `clk`, if `FlagsWriteW`, `FlagZero <= ALUFlagZeroW`; otherwise hold.
- Counter: on rising `clk`, increments by 1 if `(RegWriteW && WA3W != 15) || FlagsWriteW` (one increment even if both); saturates at 0xFFFF, never wraps.
- Reset (asynchronous, `reset` low): all 15 stored registers = 0, `FlagZero` = 0, `RetireCount` = 0. Takes effect immediately, including mid-cycle with a write pending; the pending write is lost. On deassertion, first write commits at the next rising edge.
- While `reset` is low, reads of r0–r14 return 0, r15 returns `PCPlus8D`; `ResultW` remains the combinational mux.

## Timing
- Upstream MEM/WB register updates on falling `clk`; this block commits on the following rising edge (half-cycle write-back latency).
- Without bypass, a value written at rising edge N is visible on `RDnD` immediately after edge N, i.e. before the decode-side falling-edge capture of the same cycle; no stall needed for a W→D dependency.
- Write and read of the same register in the same cycle: before the rising edge, read returns old value (bypass off) or `ResultW` (bypass on).
- `FlagZero` and `RetireCount` change only on rising edge or reset.

## Configuration
- `WB_BYPASS_EN` defined: each read port returns `ResultW` when `RegWriteW && WA3W == RAnD && RAnD != 15`, overriding array contents for the whole cycle (removes dependence on the half-cycle edge split).
- Undefined: reads return array contents only, per Operation.

## Structure
- Shared package: `DW`, `NREGS`, register-index typedef (4-bit), constant `REG_PC = 4'd15`.
- One sub-module: `regfile_2r1w` (storage array, two async read ports, one sync write port, async active-low clear); flag register, counter, result mux, r15 and bypass logic live in the top.

## Test plan
- Reset low mid-run after writing r3 = 0x1234 → r3 reads 0, `FlagZero` = 0, `RetireCount` = 0 immediately, no clock needed.
- `RegWriteW`=1, `MemtoRegW`=1, `WA3W`=5, `ReadDataW`=0xDEADBEEF, `ALUOutW`=0x1 → after rising edge `RD1D` (RA1D=5) = 0xDEADBEEF, `RetireCount` = 1.
- Write 0xAAAA to r15, `PCPlus8D`=0x100 → `RD2D` (RA2D=15) = 0x100, `RetireCount` unchanged.
- `FlagsWriteW`=1, `ALUFlagZeroW`=1 with `RegWriteW`=1 to r2 → `FlagZero`=1, r2 updated, `RetireCount` +1 only.
- Same-cycle write r7=0x55 / read r7 (old 0x11): before edge `RD1D`=0x11 (bypass off) or 0x55 (`WB_BYPASS_EN`); after edge 0x55 in both.
- Force counter to 0xFFFE, issue three writes → 0xFFFF, 0xFFFF, 0xFFFF.
